// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared core constants and fetch-stage types
package riscv_pkg;

    // Default machine width, shared by every stage of the core.
    localparam int RV_XLEN = 32;

    // addi x0, x0, 0 : the canonical bubble instruction.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // REQ  : PC valid, request may issue.
    // WAIT : one request outstanding, response will be used.
    // HOLD : response captured while decode was stalled.
    // KILL : one request outstanding whose response must be dropped.
    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        KILL = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with flush, stall and NOP fill
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   flush_i       drop contents (valid=0, NOP); highest priority
//   stall_i       hold all contents
//   load_i        capture instr_i / pc_i as a live instruction
//   instr_i, pc_i incoming instruction and its PC
//   instr_o, pc_o, pc_plus4_o, valid_o  registered IF/ID contents
module if_id_reg
    import riscv_pkg::*;
#(
    parameter int              XLEN     = RV_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            stall_i,
    input  logic            load_i,
    input  logic [XLEN-1:0] instr_i,
    input  logic [XLEN-1:0] pc_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic            valid_o
);

    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;
    logic            valid_q, valid_d;

    // PC fields are left untouched on flush/bubble: they are meaningless
    // when valid is low, and holding them saves toggling.
    always_comb begin
        instr_d    = instr_q;
        pc_d       = pc_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        if (flush_i) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (!stall_i) begin
            if (load_i) begin
                instr_d    = instr_i;
                pc_d       = pc_i;
                pc_plus4_d = pc_i + XLEN'(4);
                valid_d    = 1'b1;
            end else begin
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q    <= NOP_INSTR;
            pc_q       <= RESET_PC;
            pc_plus4_q <= RESET_PC + XLEN'(4);
            valid_q    <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    assign instr_o    = instr_q;
    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_plus4_q;
    assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32I instruction fetch: PC, imem request FSM, IF/ID
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   stall_f, stall_d          hazard unit: block new fetch / hold IF/ID
//   next_pc_src, clr_de       branch unit: redirect / flush IF/ID
//   pc_target                 redirect target from EX (low 2 bits ignored)
//   imem_req, imem_addr       instruction memory request
//   imem_ready                memory accepts the request this cycle
//   imem_rvalid, imem_rdata   memory response (one per accepted request)
//   instr_d, pc_d, pc_plus4_d, valid_d  IF/ID pipeline register
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int              XLEN     = RV_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_f,
    input  logic            stall_d,
    input  logic            next_pc_src,
    input  logic            clr_de,
    input  logic [XLEN-1:0] pc_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instr_d,
    output logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pc_plus4_d,
    output logic            valid_d
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_f_q, pc_f_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;        // PC of the outstanding / held fetch
    logic [XLEN-1:0] hold_instr_q, hold_instr_d;

    logic            accept;
    logic            load;
    logic [XLEN-1:0] load_instr;
    logic [XLEN-1:0] target_aligned;
    logic [XLEN-1:0] req_pc_plus4;

    assign target_aligned = pc_target & ~XLEN'(3);
    assign req_pc_plus4   = req_pc_q + XLEN'(4);

    // rst gates the request combinationally so nothing is issued while
    // reset is held, even between clock edges.
    assign imem_req  = (state_q == REQ) && !stall_f && !rst;
    assign imem_addr = pc_f_q;
    assign accept    = imem_req && imem_ready;

    always_comb begin
        state_d      = state_q;
        pc_f_d       = pc_f_q;
        req_pc_d     = req_pc_q;
        hold_instr_d = hold_instr_q;
        load         = 1'b0;
        load_instr   = imem_rdata;
        case (state_q)
            REQ: begin
                if (next_pc_src) begin
                    pc_f_d  = target_aligned;
                    // A request accepted alongside a redirect still gets a
                    // response, which must be swallowed.
                    state_d = accept ? KILL : REQ;
                end else if (accept) begin
                    req_pc_d = pc_f_q;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (next_pc_src) begin
                    pc_f_d  = target_aligned;
                    state_d = imem_rvalid ? REQ : KILL;
                end else if (imem_rvalid) begin
                    if (!stall_d) begin
                        load       = 1'b1;
                        load_instr = imem_rdata;
                        pc_f_d     = req_pc_plus4;
                        state_d    = REQ;
                    end else begin
                        hold_instr_d = imem_rdata;
                        state_d      = HOLD;
                    end
                end
            end
            HOLD: begin
                if (next_pc_src) begin
                    pc_f_d  = target_aligned;
                    state_d = REQ;
                end else if (!stall_d) begin
                    load       = 1'b1;
                    load_instr = hold_instr_q;
                    pc_f_d     = req_pc_plus4;
                    state_d    = REQ;
                end
            end
            KILL: begin
                if (next_pc_src) begin
                    pc_f_d = target_aligned;
                end
                if (imem_rvalid) begin
                    state_d = REQ;
                end
            end
            default: state_d = REQ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= REQ;
            pc_f_q       <= RESET_PC;
            req_pc_q     <= RESET_PC;
            hold_instr_q <= NOP_INSTR;
        end else begin
            state_q      <= state_d;
            pc_f_q       <= pc_f_d;
            req_pc_q     <= req_pc_d;
            hold_instr_q <= hold_instr_d;
        end
    end

    if_id_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_if_id (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (clr_de),
        .stall_i    (stall_d),
        .load_i     (load),
        .instr_i    (load_instr),
        .pc_i       (req_pc_q),
        .instr_o    (instr_d),
        .pc_o       (pc_d),
        .pc_plus4_o (pc_plus4_d),
        .valid_o    (valid_d)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking scoreboard bench for fetch_unit
module tb_fetch_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, stall_f, stall_d, next_pc_src, clr_de, imem_ready;
    logic [31:0] pc_target;
    logic        imem_req, imem_rvalid, valid_d;
    logic [31:0] imem_addr, imem_rdata, instr_d, pc_d, pc_plus4_d;

    fetch_unit u_dut (
        .clk(clk), .rst(rst), .stall_f(stall_f), .stall_d(stall_d),
        .next_pc_src(next_pc_src), .clr_de(clr_de), .pc_target(pc_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .valid_d(valid_d)
    );

    // Second instance exercising PC wrap from a top-of-memory reset PC.
    logic        w_zero = 1'b0, w_one = 1'b1;
    logic [31:0] w_tgt = 32'h0, w_rdata = 32'h0000_0013;
    logic        w_req, w_rvalid, w_valid;
    logic [31:0] w_addr, w_instr, w_pc, w_pc4;

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst(rst), .stall_f(w_zero), .stall_d(w_zero),
        .next_pc_src(w_zero), .clr_de(w_zero), .pc_target(w_tgt),
        .imem_req(w_req), .imem_addr(w_addr), .imem_ready(w_one),
        .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
        .instr_d(w_instr), .pc_d(w_pc), .pc_plus4_d(w_pc4), .valid_d(w_valid)
    );

    always @(posedge clk or posedge rst)
        if (rst) w_rvalid <= 1'b0;
        else     w_rvalid <= w_req;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Memory model: one outstanding request, response lat cycles after accept.
    int          lat = 1;
    int          cnt = 0;
    logic        pend;
    logic [31:0] pend_addr = 32'h0;
    assign imem_rvalid = pend && (cnt == 0);
    assign imem_rdata  = pend_addr ^ 32'hA5A5_0000;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= 1'b0;
        end else begin
            if (imem_rvalid) pend <= 1'b0;
            if (imem_req && imem_ready) begin
                pend      <= 1'b1;
                pend_addr <= imem_addr;
                cnt       <= lat - 1;
            end else if (pend && cnt != 0) begin
                cnt <= cnt - 1;
            end
        end
    end

    // Scoreboards: expected request addresses and expected IF/ID PCs.
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_pc_q[$];
    logic        stall_at_edge = 1'b0;
    int          cyc = 0;
    int          last_cyc = -1;
    logic        gap_chk = 1'b0;

    always @(posedge clk) begin
        stall_at_edge <= stall_d;
        cyc           <= cyc + 1;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (imem_req && imem_ready) begin
                check("req_expected", 32'(exp_addr_q.size() != 0), 32'd1);
                if (exp_addr_q.size() != 0) check("imem_addr", imem_addr, exp_addr_q.pop_front());
            end
            if (valid_d && !stall_at_edge) begin
                check("item_expected", 32'(exp_pc_q.size() != 0), 32'd1);
                if (exp_pc_q.size() != 0) begin
                    logic [31:0] e;
                    e = exp_pc_q.pop_front();
                    check("pc_d", pc_d, e);
                    check("instr_d", instr_d, e ^ 32'hA5A5_0000);
                    check("pc_plus4_d", pc_plus4_d, e + 32'd4);
                end
                if (gap_chk) begin
                    if (last_cyc >= 0) check("item_gap", 32'(cyc - last_cyc), 32'd2);
                    last_cyc = cyc;
                end
            end
        end
    end

    // Wrap-instance observations: first two request addresses, first IF/ID.
    logic [31:0] w_addrs[$];
    logic        w_seen = 1'b0;
    logic [31:0] w_first_pc = 32'h0, w_first_pc4 = 32'h0;

    always @(negedge clk) begin
        if (!rst && w_req && w_addrs.size() < 2) w_addrs.push_back(w_addr);
        if (!rst && w_valid && !w_seen) begin
            w_seen      = 1'b1;
            w_first_pc  = w_pc;
            w_first_pc4 = w_pc4;
        end
    end

    task automatic wait_addr(input int n);
        int k;
        for (k = 0; k < 300; k++) begin
            if (exp_addr_q.size() <= n) break;
            @(posedge clk); #1;
        end
        if (k == 300) check("addr_wait_timeout", 32'(exp_addr_q.size()), 32'(n));
    endtask

    task automatic wait_data();
        int k;
        for (k = 0; k < 300; k++) begin
            if (exp_pc_q.size() == 0) break;
            @(posedge clk); #1;
        end
        if (k == 300) check("data_wait_timeout", 32'(exp_pc_q.size()), 32'd0);
    endtask

    task automatic redirect(input logic [31:0] tgt);
        next_pc_src = 1'b1; clr_de = 1'b1; pc_target = tgt;
        @(posedge clk); #1;
        next_pc_src = 1'b0; clr_de = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},   32'(imem_req), 32'd0);
        check({tag, "_valid"}, 32'(valid_d), 32'd0);
        check({tag, "_instr"}, instr_d, 32'h0000_0013);
        check({tag, "_pc"},    pc_d, 32'h0);
        check({tag, "_pc4"},   pc_plus4_d, 32'h4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; stall_f = 1'b0; stall_d = 1'b0; next_pc_src = 1'b0;
        clr_de = 1'b0; imem_ready = 1'b1; pc_target = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        check("wrap_rst_pc4", w_pc4, 32'h0);

        // Back-to-back fetch with single-cycle memory.
        foreach (exp_addr_q[i]) ;
        for (int a = 0; a < 16; a += 4) begin
            exp_addr_q.push_back(32'(a));
            exp_pc_q.push_back(32'(a));
        end
        gap_chk = 1'b1;
        rst = 1'b0;
        wait_addr(0);
        stall_f = 1'b1;
        wait_data();
        gap_chk = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            check("stall_f_no_req", 32'(imem_req), 32'd0);
        end

        // Redirect in WAIT before the response: stale 0x10 must be dropped.
        lat = 4;
        exp_addr_q.push_back(32'h10); exp_addr_q.push_back(32'h100);
        exp_pc_q.push_back(32'h100);
        stall_f = 1'b0;
        wait_addr(1);
        redirect(32'h100);
        check("kill_no_req", 32'(imem_req), 32'd0);
        wait_addr(0);
        stall_f = 1'b1;
        wait_data();

        // Redirect in WAIT coincident with the response.
        lat = 2;
        exp_addr_q.push_back(32'h104); exp_addr_q.push_back(32'h180);
        exp_pc_q.push_back(32'h180);
        stall_f = 1'b0;
        wait_addr(1);
        @(posedge clk); #1;
        redirect(32'h180);
        wait_addr(0);
        stall_f = 1'b1;
        wait_data();

        // Redirect coincident with accept; misaligned target is aligned.
        lat = 2;
        exp_addr_q.push_back(32'h184); exp_addr_q.push_back(32'h200);
        exp_pc_q.push_back(32'h200);
        stall_f = 1'b0;
        redirect(32'h203);
        check("kill_accept_no_req", 32'(imem_req), 32'd0);
        wait_addr(0);
        stall_f = 1'b1;
        wait_data();

        // Decode stall while the response arrives: held, then delivered.
        lat = 3;
        exp_addr_q.push_back(32'h204); exp_addr_q.push_back(32'h208);
        exp_pc_q.push_back(32'h204); exp_pc_q.push_back(32'h208);
        stall_f = 1'b0;
        wait_addr(1);
        stall_d = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            check("stall_d_no_req", 32'(imem_req), 32'd0);
            check("stall_d_valid", 32'(valid_d), 32'd0);
        end
        stall_d = 1'b0;
        wait_addr(0);
        stall_f = 1'b1;
        wait_data();

        // Stall holds a live instruction; clr_de beats stall_d.
        lat = 1;
        exp_addr_q.push_back(32'h20C);
        exp_pc_q.push_back(32'h20C);
        stall_f = 1'b0;
        wait_addr(0);
        stall_f = 1'b1;
        @(posedge clk); #1;
        stall_d = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(valid_d), 32'd1);
            check("hold_pc", pc_d, 32'h20C);
            check("hold_instr", instr_d, 32'h20C ^ 32'hA5A5_0000);
        end
        clr_de = 1'b1;
        @(posedge clk); #1;
        check("flush_valid", 32'(valid_d), 32'd0);
        check("flush_instr", instr_d, 32'h0000_0013);
        clr_de = 1'b0;
        stall_d = 1'b0;

        // clr_de alone did not redirect: next fetch continues at 0x210.
        // Async reset lands mid-WAIT; its response is never delivered.
        lat = 4;
        exp_addr_q.push_back(32'h210);
        stall_f = 1'b0;
        wait_addr(0);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        exp_addr_q.push_back(32'h0);
        exp_pc_q.push_back(32'h0);
        lat = 1;
        @(posedge clk); #1;
        rst = 1'b0;
        wait_addr(0);
        stall_f = 1'b1;
        wait_data();
        repeat (3) @(posedge clk);
        #1;

        check("sb_empty", 32'(exp_addr_q.size() + exp_pc_q.size()), 32'd0);
        check("wrap_count", 32'(w_addrs.size() >= 2), 32'd1);
        if (w_addrs.size() >= 2) begin
            check("wrap_addr0", w_addrs[0], 32'hFFFF_FFFC);
            check("wrap_addr1", w_addrs[1], 32'h0000_0000);
        end
        check("wrap_first_pc", w_first_pc, 32'hFFFF_FFFC);
        check("wrap_first_pc4", w_first_pc4, 32'h0000_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the 5-stage pipelined RV32I core: owns the PC register, issues instruction-memory requests and drives the IF/ID pipeline register.
- Consumes the branch unit's redirect (next_pc_src, clr_de) and the EX-stage target address.
- Supports variable-latency memory with one outstanding request, plus stall and flush.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- XLEN, 32, address/instruction width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall_f  in  1  hazard unit: do not issue a new fetch request.
- stall_d  in  1  hazard unit: hold IF/ID contents.
- next_pc_src  in  1  branch unit: redirect taken this cycle.
- clr_de  in  1  branch unit: flush IF/ID.
- pc_target  in  XLEN  redirect target from EX.
- imem_req  out  1  request valid.
- imem_addr  out  XLEN  request address.
- imem_ready  in  1  memory accepts request this cycle.
- imem_rvalid  in  1  response valid (exactly one per accepted request).
- imem_rdata  in  XLEN  instruction word.
- instr_d  out  XLEN  IF/ID instruction.
- pc_d  out  XLEN  IF/ID PC.
- pc_plus4_d  out  XLEN  IF/ID PC+4.
- valid_d  out  1  IF/ID holds a live instruction.

Behaviour:
- Reset (async, rst=1): pc_f=RESET_PC, state=REQ, hold buffer empty, instr_d=NOP (32'h0000_0013), pc_d=RESET_PC, pc_plus4_d=RESET_PC+4, valid_d=0. imem_req=0 while rst is high.
- imem_req=1 only in state REQ with stall_f=0. imem_addr=pc_f. pc_target[1:0] is forced to 2'b00 on load.
- States:
  - REQ
    - Request accepted (imem_req && imem_ready), no redirect: latch req_pc=pc_f, go WAIT.
    - Redirect with no accept: pc_f<=pc_target, stay REQ.
    - Redirect in the same cycle as accept: pc_f<=pc_target, go KILL (stale response pending).
  - WAIT
    - imem_rvalid, no redirect, stall_d=0: load IF/ID (instr_d=imem_rdata, pc_d=req_pc, pc_plus4_d=req_pc+4, valid_d=1); pc_f<=req_pc+4; go REQ. Next request may issue the following cycle (fetch throughput 1 per 2 cycles minimum).
    - imem_rvalid, no redirect, stall_d=1: capture the response in the hold buffer, go HOLD.
    - Redirect with imem_rvalid: discard the response, pc_f<=pc_target, go REQ.
    - Redirect without imem_rvalid: pc_f<=pc_target, go KILL.
  - HOLD
    - stall_d falls and no redirect: move buffer to IF/ID, pc_f<=held_pc+4, go REQ.
    - Redirect: discard buffer, pc_f<=pc_target, go REQ.
  - KILL
    - imem_rvalid: discard, go REQ. pc_f already holds the target.
    - A further redirect while in KILL overwrites pc_f and stays KILL.
- IF/ID priority: clr_de > stall_d > load.
  - clr_de=1: valid_d<=0, instr_d<=NOP; pc_d and pc_plus4_d are don't-care but held.
  - stall_d=1 (no clr_de): all IF/ID outputs hold.
  - No load event and no stall: valid_d<=0, instr_d<=NOP (bubble).
- next_pc_src is always paired with clr_de by the branch unit. The block must behave correctly if clr_de alone is asserted: flush only, no redirect.
- Arithmetic: PC+4 wraps modulo 2^32 (32'hFFFF_FFFC+4=0). No exceptions raised.
- rst asserted mid-transaction: any later imem_rvalid belonging to the old request is the memory's responsibility. The block returns to REQ at RESET_PC.

Decomposition:
- riscv_pkg:
  - NOP_INSTR constant.
  - fetch_state_t enum {REQ, WAIT, HOLD, KILL}.
  - XLEN default shared with the rest of the core.
- One sub-module: if_id_reg (flush/stall/load pipeline register with NOP fill).
- fetch_unit instantiates if_id_reg plus the PC/FSM logic.

Test Plan:
- Reset then zero-latency memory (imem_ready=1, rvalid the cycle after accept), rdata=addr^32'hA5A5_0000 -> pc_d sequence 0,4,8,C; instr_d matches; valid_d=1 every 2nd cycle.
- Redirect in WAIT: request for 0x8 outstanding, next_pc_src=1, pc_target=0x100, response arrives 3 cycles later -> response discarded, next imem_addr=0x100, valid_d never shows pc_d=0x8.
- Redirect coincident with accept in REQ (pc_f=0x10, target=0x203) -> KILL entered, stale rvalid dropped, next imem_addr=0x200.
- stall_d=1 for 4 cycles as the response for 0x20 arrives -> IF/ID holds its prior instruction, no new imem_req. After release, pc_d=0x20, then imem_addr=0x24.
- clr_de with stall_d both high -> valid_d=0, instr_d=32'h0000_0013 next cycle.
- Async rst pulse between clock edges while in WAIT -> outputs at reset values immediately, first request after release at RESET_PC. Wrap test: RESET_PC=32'hFFFF_FFFC -> second fetch address 0x0.
